serial_frame_deserializer: RTL and testbench

- Consumes the registered serial bit stream produced by the D flip-flop sampling stage.
- Strips start/stop framing and assembles `WIDTH`-bit words (LSB first).
- Presents each word on a valid/ready output register.
- Reports framing and overrun errors as single-cycle pulses.

---
 rtl/serial_frame_deserializer.sv | 125 ++++++++++++
 tb/tb_serial_frame_deserializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_deserializer.sv
// Strips start/stop framing from a sampled serial bit stream and assembles WIDTH-bit LSB-first words.
// Define SERIAL_FRAME_DESERIALIZER_PARITY_EN to add an even-parity bit between data and stop.
module serial_frame_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             parity_err,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_bad;
    logic             word_done;

`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
    logic par_acc;
    logic parity_err_q;
    assign parity_err = parity_err_q;
`else
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // A word is only kept when the stop bit is 1 and the parity bit (if any) matched.
    assign word_done = bit_valid && (state == STOP) && bit_in && !par_bad;

    // NOTE: every register here, including the shift register, uses non-blocking
    // assignments and is cleared by the async reset so a partial frame leaves no trace.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
            par_acc      <= 1'b0;
            par_bad      <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
            parity_err_q <= 1'b0;
`endif
            // The output register is handled every cycle, independent of bit strobes.
            if (word_done) begin
                if (!out_valid || out_ready) begin
                    out_data  <= shreg;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (bit_valid) begin
                case (state)
                    IDLE: begin
                        if (!bit_in) begin
                            state <= DATA;
                            cnt   <= '0;
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
                            par_acc <= 1'b0;
`endif
                        end
                    end
                    DATA: begin
                        shreg <= {bit_in, shreg[WIDTH-1:1]};
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
                        par_acc <= par_acc ^ bit_in;
`endif
                        if (cnt == CW'(WIDTH - 1)) begin
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
                    PARITY: begin
                        par_bad <= (bit_in != par_acc);
                        state   <= STOP;
                    end
`endif
                    STOP: begin
                        // A 0 stop bit is a framing error, never a new start bit.
                        frame_err <= !bit_in;
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
                        parity_err_q <= par_bad;
`endif
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_deserializer.sv
// Self-checking bench for serial_frame_deserializer: frame-level reference model plus directed
// literal checks. Compile with SERIAL_FRAME_DESERIALIZER_PARITY_EN to exercise the parity path.
module tb_serial_frame_deserializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         bit_valid;
    logic         bit_in;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;
    logic         frame_err;
    logic         parity_err;
    logic         overrun;

    int errors = 0;
    int checks = 0;

    // Reference model state: what the outputs must show after the most recent edge.
    logic [W-1:0] m_data;
    logic         m_valid;
    logic         m_fe;
    logic         m_pe;
    logic         m_ov;

    serial_frame_deserializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("out_data", 32'(out_data), 32'(m_data));
        check("frame_err", 32'(frame_err), 32'(m_fe));
        check("parity_err", 32'(parity_err), 32'(m_pe));
        check("overrun", 32'(overrun), 32'(m_ov));
    endtask

    task automatic model_reset();
        m_data  = '0;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_pe    = 1'b0;
        m_ov    = 1'b0;
    endtask

    // One clock: drive inputs, advance the model by frame-level rules, then compare after the edge.
    // is_stop/pbad/word describe the frame whose stop bit is being presented.
    task automatic step(input logic bv, input logic bi, input logic rdy,
                        input logic is_stop, input logic pbad, input logic [W-1:0] word);
        logic stop_edge;
        logic done;
        bit_valid = bv;
        bit_in    = bi;
        out_ready = rdy;
        stop_edge = bv && is_stop;
        done      = stop_edge && bi && !pbad;
        m_fe = stop_edge && !bi;
        m_pe = stop_edge && pbad;
        m_ov = 1'b0;
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid = 1'b1;
                m_data  = word;
            end else begin
                m_ov = 1'b1;
            end
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        compare_all();
    endtask

    // rdy_mode: 0 low, 1 high, 2 random, 3 low except high on the stop edge
    function automatic logic pick_rdy(input int mode, input logic at_stop);
        case (mode)
            0: return 1'b0;
            1: return 1'b1;
            2: return 1'($urandom_range(0, 1));
            default: return at_stop;
        endcase
    endfunction

    // gap = cycles per strobe (1 = every cycle); gap 0 = random 1..3
    task automatic send_frame(input logic [W-1:0] word, input logic stop_b, input logic par_flip,
                              input int gap, input int rdy_mode);
        logic bits[$];
        logic pbad;
        int   g;
        bits.push_back(1'b0);
        for (int i = 0; i < W; i++) bits.push_back(word[i]);
`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
        bits.push_back((^word) ^ par_flip);
        pbad = par_flip;
`else
        pbad = 1'b0;
`endif
        bits.push_back(stop_b);
        for (int i = 0; i < bits.size(); i++) begin
            g = (gap == 0) ? int'($urandom_range(1, 3)) : gap;
            for (int k = 1; k < g; k++)
                step(1'b0, 1'($urandom_range(0, 1)), pick_rdy(rdy_mode, 1'b0), 1'b0, 1'b0, '0);
            step(1'b1, bits[i], pick_rdy(rdy_mode, i == bits.size() - 1),
                 i == bits.size() - 1, pbad, word);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;

        // Basic frame, strobe every cycle
        send_frame(8'h3C, 1'b1, 1'b0, 1, 1);
        check("basic_valid", 32'(out_valid), 32'd1);
        check("basic_data", 32'(out_data), 32'h3C);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("basic_consumed", 32'(out_valid), 32'd0);

        // Sparse strobes
        send_frame(8'h3C, 1'b1, 1'b0, 3, 1);
        check("sparse_valid", 32'(out_valid), 32'd1);
        check("sparse_data", 32'(out_data), 32'h3C);

        // Framing error then recovery
        send_frame(8'h99, 1'b0, 1'b0, 1, 1);
        check("ferr_pulse", 32'(frame_err), 32'd1);
        check("ferr_no_word", 32'(out_valid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("ferr_single", 32'(frame_err), 32'd0);
        send_frame(8'h55, 1'b1, 1'b0, 1, 1);
        check("ferr_recover", 32'(out_data), 32'h55);

        // Overrun with out_ready low, then completion with ready on the edge
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        send_frame(8'h11, 1'b1, 1'b0, 1, 0);
        check("ovr_first", 32'(out_data), 32'h11);
        send_frame(8'h22, 1'b1, 1'b0, 1, 0);
        check("ovr_pulse", 32'(overrun), 32'd1);
        check("ovr_keep", 32'(out_data), 32'h11);
        send_frame(8'h22, 1'b1, 1'b0, 1, 3);
        check("ovr_none", 32'(overrun), 32'd0);
        check("ovr_replace", 32'(out_data), 32'h22);

        // Reset mid-DATA with a word held: everything clears at once, no pulse
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, '0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_pulses", {29'd0, frame_err, parity_err, overrun}, 32'd0);
        bit_valid = 1'b0;
        @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1, 1);
        check("rst_recover", 32'(out_data), 32'hA5);

`ifdef SERIAL_FRAME_DESERIALIZER_PARITY_EN
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
        send_frame(8'h07, 1'b1, 1'b1, 1, 1);
        check("par_pulse", 32'(parity_err), 32'd1);
        check("par_no_word", 32'(out_valid), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0, 1, 1);
        check("par_good", 32'(out_data), 32'h07);
        check("par_good_valid", 32'(out_valid), 32'd1);
`endif

        // Randomized traffic: back-to-back or gapped frames, random errors and back-pressure
        for (int f = 0; f < 250; f++) begin
            int nidle;
            nidle = int'($urandom_range(0, 2));
            for (int k = 0; k < nidle; k++)
                step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, '0);
            send_frame(W'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
                       0, 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
